// File: rtl/simon_pkg.sv
// Shared Simon definitions: z constant sequences, standard variant table,
// width-parametrised rotate, and the key-expander state enum.
package simon_pkg;

  // z sequences; the published leftmost character sits in bit 61.
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

  typedef struct packed {
    int n;
    int m;
    int t;
    int zseq;
  } simon_variant_t;

  // Simon32/64, 48/72, 48/96, 64/96, 64/128, 96/96, 96/144, 128/128, 128/192, 128/256.
  localparam simon_variant_t SIMON_VARIANTS [10] = '{
    '{16, 4, 32, 0}, '{24, 3, 36, 0}, '{24, 4, 36, 1}, '{32, 3, 42, 2},
    '{32, 4, 44, 3}, '{48, 2, 52, 2}, '{48, 3, 54, 3}, '{64, 2, 68, 2},
    '{64, 3, 69, 3}, '{64, 4, 72, 4}
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXP  = 2'd1,
    ST_DONE = 2'd2
  } kexp_state_e;

  // Rotate right by r within the low w bits of x (w <= 64, bits above w cleared).
  function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned r,
                                      input int unsigned w);
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return ((x >> r) | (x << (w - r))) & mask;
  endfunction

  // Bit j of sequence seq, j counted from the leftmost published character.
  function automatic logic z_bit(input int unsigned seq, input logic [5:0] j);
    logic [61:0] z;
    case (seq)
      0:       z = Z0;
      1:       z = Z1;
      2:       z = Z2;
      3:       z = Z3;
      default: z = Z4;
    endcase
    return z[6'd61 - j];
  endfunction

endpackage

// File: rtl/simon_kexp_step.sv
// Combinational Simon round-key function: k[i] from k[i-1], k[i-3], k[i-M] and one z bit.
module simon_kexp_step
  import simon_pkg::*;
#(
  parameter int N = 32,
  parameter int M = 4
) (
  input  logic [N-1:0] k_im1_i,
  input  logic [N-1:0] k_im3_i,
  input  logic [N-1:0] k_imm_i,
  input  logic         z_i,
  output logic [N-1:0] k_o
);

  logic [N-1:0] t3;
  logic [N-1:0] t1;

  // ROR3, fold in k[i-3] for four-word keys, self-xor with ROR1, then mix constant.
  always_comb begin
    t3 = N'(ror(64'(k_im1_i), 3, N));
    if (M == 4) t3 = t3 ^ k_im3_i;
    t1 = t3 ^ N'(ror(64'(t3), 1, N));
    k_o = ~k_imm_i ^ t1 ^ N'(z_i) ^ N'(3);
  end

endmodule

// File: rtl/simon_kexp_gen.sv
// Simon key expander: loads an M-word key, generates one round key per cycle into a
// T-entry store, and serves keys through a random-access port and an ordered stream.
module simon_kexp_gen
  import simon_pkg::*;
#(
  parameter int N    = 32,
  parameter int M    = 4,
  parameter int T    = 44,
  parameter int ZSEQ = 3,
  parameter int IW   = $clog2(T)
) (
  input  logic           ck,
  input  logic           nrst,
  input  logic [M*N-1:0] key,
  input  logic           dir,
  input  logic           k_valid,
  output logic           k_ready,
  input  logic           clear,
  input  logic [IW-1:0]  rd_addr,
  output logic [N-1:0]   rd_data,
  output logic           rd_hit,
  output logic [IW:0]    gen_count,
  output logic           exp_valid,
  output logic           rk_valid,
  input  logic           rk_ready,
  output logic [N-1:0]   rk_data,
  output logic [IW-1:0]  rk_index,
  output logic           rk_last
);

  // k[i-3] tap only exists for four-word keys; keep the index legal otherwise.
  localparam int          IM3      = (M >= 3) ? M - 3 : 0;
  localparam logic [IW:0] GEN_M    = (IW+1)'(M);
  localparam logic [IW:0] GEN_LAST = (IW+1)'(T-1);
  localparam logic [IW-1:0] IDX_LAST = IW'(T-1);

  kexp_state_e   state_q, state_d;
  logic [IW:0]   gen_q, gen_d;
  logic [5:0]    zidx_q, zidx_d;      // (i-M) mod 62, wraps 61 -> 0
  logic          dir_q, dir_d;
  logic [IW-1:0] ptr_q, ptr_d;        // stream pointer
  logic          sdone_q, sdone_d;    // stream finished its last word
  logic          load, gen_we;
  logic          z_cur;
  logic [N-1:0]  k_new;
  logic [N-1:0]  store_q [T];
  logic [N-1:0]  win_q [M];           // win_q[0] = k[i-M] ... win_q[M-1] = k[i-1]

  assign z_cur = z_bit(ZSEQ, zidx_q);

  simon_kexp_step #(.N(N), .M(M)) u_step (
    .k_im1_i (win_q[M-1]),
    .k_im3_i (win_q[IM3]),
    .k_imm_i (win_q[0]),
    .z_i     (z_cur),
    .k_o     (k_new)
  );

  assign k_ready   = (state_q != ST_EXP);
  assign exp_valid = (state_q == ST_DONE);
  assign gen_count = gen_q;
  assign rd_hit    = ({1'b0, rd_addr} < gen_q);
  assign rd_data   = (rd_addr <= IDX_LAST) ? store_q[rd_addr] : '0;

  // Forward stream trails generation; reverse stream waits for the full schedule.
  assign rk_valid = !sdone_q && (dir_q ? (state_q == ST_DONE) : ({1'b0, ptr_q} < gen_q));
  assign rk_data  = store_q[ptr_q];
  assign rk_index = ptr_q;
  assign rk_last  = rk_valid && (ptr_q == (dir_q ? '0 : IDX_LAST));

  // Next-state: clear beats key load, key load beats generation and stream stepping.
  always_comb begin
    state_d = state_q;
    gen_d   = gen_q;
    zidx_d  = zidx_q;
    dir_d   = dir_q;
    ptr_d   = ptr_q;
    sdone_d = sdone_q;
    load    = 1'b0;
    gen_we  = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      gen_d   = '0;
      zidx_d  = '0;
      ptr_d   = '0;
      sdone_d = 1'b0;
    end else if (k_valid && k_ready) begin
      load    = 1'b1;
      state_d = ST_EXP;
      gen_d   = GEN_M;
      zidx_d  = '0;
      dir_d   = dir;
      ptr_d   = dir ? IDX_LAST : '0;
      sdone_d = 1'b0;
    end else begin
      if (state_q == ST_EXP) begin
        gen_we = 1'b1;
        gen_d  = gen_q + (IW+1)'(1);
        zidx_d = (zidx_q == 6'd61) ? 6'd0 : zidx_q + 6'd1;
        if (gen_q == GEN_LAST) state_d = ST_DONE;
      end
      if (rk_valid && rk_ready) begin
        if (rk_last)    sdone_d = 1'b1;
        else if (dir_q) ptr_d   = ptr_q - IW'(1);
        else            ptr_d   = ptr_q + IW'(1);
      end
    end
  end

  // Control registers, including the FSM state.
  always_ff @(posedge ck) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      gen_q   <= '0;
      zidx_q  <= '0;
      dir_q   <= 1'b0;
      ptr_q   <= '0;
      sdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gen_q   <= gen_d;
      zidx_q  <= zidx_d;
      dir_q   <= dir_d;
      ptr_q   <= ptr_d;
      sdone_q <= sdone_d;
    end
  end

  // Round-key store: zeroed on reset, key words on load, one generated word per EXP cycle.
  always_ff @(posedge ck) begin
    if (!nrst) begin
      for (int j = 0; j < T; j++) store_q[j] <= '0;
    end else if (load) begin
      for (int j = 0; j < M; j++) store_q[j] <= key[j*N +: N];
    end else if (gen_we) begin
      store_q[gen_q[IW-1:0]] <= k_new;
    end
  end

  // Sliding window of the last M keys feeding the step function.
  always_ff @(posedge ck) begin
    if (load) begin
      for (int j = 0; j < M; j++) win_q[j] <= key[j*N +: N];
    end else if (gen_we) begin
      for (int j = 0; j < M-1; j++) win_q[j] <= win_q[j+1];
      win_q[M-1] <= k_new;
    end
  end

endmodule

// File: tb/tb_simon_kexp_gen.sv
// Bench for simon_kexp_gen: three variants (32/64, 128/128, 96/144) against an
// array-based key-schedule model.
module tb_simon_kexp_gen;

  logic ck = 1'b0;
  logic nrst = 1'b0;
  always #5 ck = ~ck;

  int ncmp = 0;
  int nbad = 0;

  string       zstr [5];
  logic [63:0] kw [4];
  logic [63:0] mk [72];

  // Simon32/64
  logic [63:0] a_key;
  logic a_dir, a_kv, a_kr, a_clr, a_rdh, a_ev, a_rv, a_rr, a_rl;
  logic [4:0] a_rda, a_ridx;
  logic [15:0] a_rdd, a_rdat;
  logic [5:0] a_gc;
  // Simon128/128
  logic [127:0] b_key;
  logic b_dir, b_kv, b_kr, b_clr, b_rdh, b_ev, b_rv, b_rr, b_rl;
  logic [6:0] b_rda, b_ridx;
  logic [63:0] b_rdd, b_rdat;
  logic [7:0] b_gc;
  // Simon96/144
  logic [143:0] c_key;
  logic c_dir, c_kv, c_kr, c_clr, c_rdh, c_ev, c_rv, c_rr, c_rl;
  logic [5:0] c_rda, c_ridx;
  logic [47:0] c_rdd, c_rdat;
  logic [6:0] c_gc;

  simon_kexp_gen #(.N(16), .M(4), .T(32), .ZSEQ(0)) dut_a (
    .ck(ck), .nrst(nrst), .key(a_key), .dir(a_dir), .k_valid(a_kv), .k_ready(a_kr),
    .clear(a_clr), .rd_addr(a_rda), .rd_data(a_rdd), .rd_hit(a_rdh), .gen_count(a_gc),
    .exp_valid(a_ev), .rk_valid(a_rv), .rk_ready(a_rr), .rk_data(a_rdat),
    .rk_index(a_ridx), .rk_last(a_rl));

  simon_kexp_gen #(.N(64), .M(2), .T(68), .ZSEQ(2)) dut_b (
    .ck(ck), .nrst(nrst), .key(b_key), .dir(b_dir), .k_valid(b_kv), .k_ready(b_kr),
    .clear(b_clr), .rd_addr(b_rda), .rd_data(b_rdd), .rd_hit(b_rdh), .gen_count(b_gc),
    .exp_valid(b_ev), .rk_valid(b_rv), .rk_ready(b_rr), .rk_data(b_rdat),
    .rk_index(b_ridx), .rk_last(b_rl));

  simon_kexp_gen #(.N(48), .M(3), .T(54), .ZSEQ(3)) dut_c (
    .ck(ck), .nrst(nrst), .key(c_key), .dir(c_dir), .k_valid(c_kv), .k_ready(c_kr),
    .clear(c_clr), .rd_addr(c_rda), .rd_data(c_rdd), .rd_hit(c_rdh), .gen_count(c_gc),
    .exp_valid(c_ev), .rk_valid(c_rv), .rk_ready(c_rr), .rk_data(c_rdat),
    .rk_index(c_ridx), .rk_last(c_rl));

  typedef struct {
    logic [4:0]  addr;
    logic        hit;
    logic [15:0] data;
  } rdvec_t;
  rdvec_t rtab [6];

  task automatic tick;
    @(posedge ck);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] mror(input logic [63:0] x, input int r, input int n);
    logic [63:0] mask;
    mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    return ((x >> r) | (x << (n - r))) & mask;
  endfunction

  // Whole key schedule k[0..t-1] from kw[], straight from the recurrence.
  task automatic model(input int n, input int m, input int t, input int zs);
    logic [63:0] mask, tmp, zb;
    mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    for (int i = 0; i < m; i++) mk[i] = kw[i] & mask;
    for (int i = m; i < t; i++) begin
      tmp = mror(mk[i-1], 3, n);
      if (m == 4) tmp = tmp ^ mk[i-3];
      tmp = tmp ^ mror(tmp, 1, n);
      zb  = (zstr[zs].getc((i - m) % 62) == 8'd49) ? 64'd1 : 64'd0;
      mk[i] = (~mk[i-m] ^ tmp ^ zb ^ 64'd3) & mask;
    end
  endtask

  task automatic set_fixed_a;
    kw[0] = 64'h0100; kw[1] = 64'h0908; kw[2] = 64'h1110; kw[3] = 64'h1918;
    a_key = {kw[3][15:0], kw[2][15:0], kw[1][15:0], kw[0][15:0]};
  endtask

  task automatic sweep_a(input string tag);
    for (int i = 0; i < 32; i++) begin
      a_rda = 5'(i);
      #1;
      chk($sformatf("%s_hit[%0d]", tag, i), a_rdh, 1);
      chk($sformatf("%s_key[%0d]", tag, i), a_rdd, mk[i]);
    end
  endtask

  task automatic wait_a_gc(input int g);
    int n = 0;
    while (int'(a_gc) != g && n < 200) begin tick; n++; end
    chk("a_wait_gen_count", a_gc, g);
  endtask

  task automatic wait_a_ev;
    int n = 0;
    while (!a_ev && n < 200) begin tick; n++; end
    chk("a_wait_exp_valid", a_ev, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ei, g;
    logic stalled;
    logic [63:0] pidx, pdat, plast;

    zstr[0] = "11111010001001010110000111001101111101000100101011000011100110";
    zstr[1] = "10001110111110010011000010110101000111011111001001100001011010";
    zstr[2] = "10101111011100000011010010011000101000010001111110010110110011";
    zstr[3] = "11011011101011000110010111100000010010001010011100110100001111";
    zstr[4] = "11010001111001101011011000100000010111000011001010010011101111";
    rtab[0] = '{5'd0,  1'b1, 16'h0100};
    rtab[1] = '{5'd1,  1'b1, 16'h0908};
    rtab[2] = '{5'd2,  1'b1, 16'h1110};
    rtab[3] = '{5'd3,  1'b1, 16'h1918};
    rtab[4] = '{5'd4,  1'b0, 16'h0000};
    rtab[5] = '{5'd31, 1'b0, 16'h0000};

    a_key = '0; a_dir = 0; a_kv = 0; a_clr = 0; a_rda = '0; a_rr = 0;
    b_key = '0; b_dir = 0; b_kv = 0; b_clr = 0; b_rda = '0; b_rr = 0;
    c_key = '0; c_dir = 0; c_kv = 0; c_clr = 0; c_rda = '0; c_rr = 0;

    // Reset
    nrst = 0;
    repeat (3) tick;
    nrst = 1;
    #1;
    chk("rst_k_ready", a_kr, 1);
    chk("rst_gen_count", a_gc, 0);
    chk("rst_exp_valid", a_ev, 0);
    chk("rst_rk_valid", a_rv, 0);
    chk("rst_rk_last", a_rl, 0);
    chk("rst_rk_index", a_ridx, 0);
    chk("rst_rk_data", a_rdat, 0);
    chk("rst_rd_hit", a_rdh, 0);
    chk("rst_b_gen_count", b_gc, 0);
    chk("rst_c_rk_valid", c_rv, 0);

    // Simon32/64 known vector
    set_fixed_a;
    model(16, 4, 32, 0);
    a_kv = 1;
    tick;
    a_kv = 0;
    chk("a_load_gen_count", a_gc, 4);
    chk("a_load_k_ready", a_kr, 0);
    chk("a_load_exp_valid", a_ev, 0);
    chk("a_load_rk_valid", a_rv, 1);
    chk("a_load_rk_index", a_ridx, 0);
    chk("a_load_rk_data", a_rdat, 16'h0100);
    chk("a_load_rk_last", a_rl, 0);
    foreach (rtab[e]) begin
      a_rda = rtab[e].addr;
      #1;
      chk($sformatf("a_tab_hit[%0d]", rtab[e].addr), a_rdh, rtab[e].hit);
      chk($sformatf("a_tab_data[%0d]", rtab[e].addr), a_rdd, rtab[e].data);
    end
    for (int c = 1; c <= 28; c++) begin
      tick;
      if (c == 27) chk("a_exp_valid_early", a_ev, 0);
    end
    chk("a_exp_valid_at_L29", a_ev, 1);
    chk("a_stalled_rk_index", a_ridx, 0);
    sweep_a("a_sched");
    a_rda = 5'd4;
    #1;
    chk("a_k4_vector", a_rdd, 16'h71C3);

    // Stream a few words, then restart with a new key in DONE
    a_rr = 1;
    repeat (5) tick;
    a_rr = 0;
    chk("a_stream_progress", a_ridx, 5);
    a_kv = 1;
    tick;
    a_kv = 0;
    chk("a_restart_gen_count", a_gc, 4);
    chk("a_restart_rk_index", a_ridx, 0);
    chk("a_restart_rk_valid", a_rv, 1);
    repeat (3) tick;
    a_key = {$urandom, $urandom};
    a_kv = 1;
    #1;
    chk("a_k_ready_in_exp", a_kr, 0);
    tick;
    a_kv = 0;
    chk("a_ignored_key_gen_count", a_gc, 8);
    wait_a_ev;
    sweep_a("a_ignored");

    // Read port at the word about to be written
    set_fixed_a;
    a_kv = 1;
    tick;
    a_kv = 0;
    tick;
    tick;
    g = int'(a_gc);
    chk("a_gc_before_probe", a_gc, 6);
    a_rda = 5'(g);
    #1;
    chk("a_probe_miss", a_rdh, 0);
    tick;
    chk("a_probe_hit", a_rdh, 1);
    chk("a_probe_data", a_rdd, mk[g]);

    // clear at gen_count = 10
    wait_a_gc(10);
    a_clr = 1;
    tick;
    a_clr = 0;
    chk("a_clear_k_ready", a_kr, 1);
    chk("a_clear_gen_count", a_gc, 0);
    chk("a_clear_rk_valid", a_rv, 0);
    chk("a_clear_exp_valid", a_ev, 0);

    // Simon128/128 forward stream with random back-pressure
    kw[0] = {$urandom, $urandom};
    kw[1] = {$urandom, $urandom};
    model(64, 2, 68, 2);
    b_key = {kw[1], kw[0]};
    b_dir = 0;
    b_kv = 1;
    tick;
    b_kv = 0;
    ei = 0;
    stalled = 0;
    pidx = '0; pdat = '0; plast = '0;
    for (int c = 0; c < 1000 && ei < 68; c++) begin
      b_rr = 1'($urandom_range(0, 1));
      if (stalled) begin
        chk("b_hold_valid", b_rv, 1);
        chk("b_hold_index", b_ridx, pidx);
        chk("b_hold_data", b_rdat, pdat);
        chk("b_hold_last", b_rl, plast);
      end
      if (b_rv) begin
        chk($sformatf("b_index[%0d]", ei), b_ridx, ei);
        chk($sformatf("b_data[%0d]", ei), b_rdat, mk[ei]);
        chk($sformatf("b_last[%0d]", ei), b_rl, (ei == 67) ? 1 : 0);
        if (b_rr) ei++;
      end
      stalled = b_rv && !b_rr;
      pidx = 64'(b_ridx); pdat = b_rdat; plast = 64'(b_rl);
      tick;
    end
    chk("b_stream_words", ei, 68);
    b_rr = 1;
    for (int c = 0; c < 3; c++) begin
      chk("b_after_last_valid", b_rv, 0);
      tick;
    end

    // Simon96/144 reverse stream
    kw[0] = {16'h0, $urandom_range(0, 65535), $urandom};
    kw[1] = {16'h0, $urandom_range(0, 65535), $urandom};
    kw[2] = {16'h0, $urandom_range(0, 65535), $urandom};
    model(48, 3, 54, 3);
    c_key = {kw[2][47:0], kw[1][47:0], kw[0][47:0]};
    c_dir = 1;
    c_rr = 1;
    c_kv = 1;
    tick;
    c_kv = 0;
    g = 0;
    while (!c_ev && g < 200) begin
      chk("c_valid_before_done", c_rv, 0);
      tick;
      g++;
    end
    chk("c_exp_cycles", g, 51);
    for (int e = 53; e >= 0; e--) begin
      chk($sformatf("c_valid[%0d]", e), c_rv, 1);
      chk($sformatf("c_index[%0d]", e), c_ridx, e);
      chk($sformatf("c_data[%0d]", e), c_rdat, mk[e]);
      chk($sformatf("c_last[%0d]", e), c_rl, (e == 0) ? 1 : 0);
      tick;
    end
    chk("c_after_last_valid", c_rv, 0);

    // Reset in the middle of expansion
    set_fixed_a;
    a_kv = 1;
    tick;
    a_kv = 0;
    wait_a_gc(10);
    nrst = 0;
    tick;
    chk("a_nrst_k_ready", a_kr, 1);
    chk("a_nrst_gen_count", a_gc, 0);
    chk("a_nrst_rk_valid", a_rv, 0);
    chk("a_nrst_exp_valid", a_ev, 0);
    for (int i = 0; i < 32; i++) begin
      a_rda = 5'(i);
      #1;
      chk($sformatf("a_nrst_hit[%0d]", i), a_rdh, 0);
      chk($sformatf("a_nrst_data[%0d]", i), a_rdd, 0);
    end
    nrst = 1;
    tick;
    chk("a_post_reset_gen_count", a_gc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
